// File: rtl/ms_port_ctrl.sv
// ms_port_ctrl
// 32x16 I/O port register bank on the MaquinaSencilla port bus
// (dirport/inport/outport/we). A host/debug requester such as a loader or
// monitor shares the bank through a req/gnt/done handshake.
// The bank has a single write port. A CPU write is never delayed. A host write
// that meets a CPU write is deferred. If the collision persists for MAX_WAIT
// cycles, ms_hold asks the CPU to stop writing so the host write can land.

module ms_port_ctrl #(
  parameter logic [15:0] INIT0    = 16'd2,  // reset value of port 0
  parameter logic [15:0] INIT1    = 16'd4,  // reset value of port 1
  parameter int unsigned MAX_WAIT = 4       // deferred cycles before ms_hold (1..15)
) (
  input  logic        clk,
  input  logic        reset,
  // CPU port bus
  input  logic [4:0]  dirport,
  input  logic [15:0] outport,
  input  logic        we,
  output logic [15:0] inport,
  output logic        ms_hold,
  // host requester
  input  logic        h_req,
  input  logic        h_we,
  input  logic [4:0]  h_addr,
  input  logic [15:0] h_wdata,
  output logic        h_gnt,
  output logic        h_done,
  output logic [15:0] h_rdata,
  // statistics
  output logic [15:0] conflict_cnt
);

  localparam int unsigned NUM_PORTS    = 32;
  localparam logic [3:0]  MAX_WAIT_CNT = 4'(MAX_WAIT);
  localparam logic [15:0] CNT_SAT      = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_WAIT,
    ST_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q;

  // Host transaction captured at the h_req edge. These fields stay fixed
  // while the transaction runs, whatever the h_* pins do after capture.
  logic        h_we_q;
  logic [4:0]  h_addr_q;
  logic [15:0] h_wdata_q;

  // Registered handshake outputs
  logic        h_gnt_q;
  logic        h_done_q;
  logic        ms_hold_q;
  logic [15:0] h_rdata_q;

  // Counters
  logic [3:0]  wait_cnt_q;
  logic [3:0]  wait_cnt_d;
  logic [15:0] conflict_cnt_q;
  logic [15:0] conflict_cnt_d;

  // Port register bank
  logic [15:0] bank_q [NUM_PORTS];

  // Single write port arbitration
  logic        host_wr_d;
  logic        bank_we_d;
  logic [4:0]  bank_waddr_d;
  logic [15:0] bank_wdata_d;

  // ---------------------------------------------------------------------------
  // Next-value logic: saturating counters and write-port mux
  // ---------------------------------------------------------------------------

  // Saturating increments for the wait and conflict counters, and the write-port
  // mux. A CPU write always wins. The host writes only in ACC or WAIT, and
  // only in a cycle when the CPU leaves the port free.
  always_comb begin
    // NOTE: every output of a combinational block gets a default value first,
    // so a path that does not assign it cannot infer a latch.
    wait_cnt_d     = wait_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    host_wr_d      = 1'b0;
    bank_we_d      = 1'b0;
    bank_waddr_d   = dirport;
    bank_wdata_d   = outport;

    if (wait_cnt_q != MAX_WAIT_CNT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    if (conflict_cnt_q != CNT_SAT) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    host_wr_d = h_we_q && !we && ((state_q == ST_ACC) || (state_q == ST_WAIT));

    if (we) begin
      bank_we_d    = 1'b1;
      bank_waddr_d = dirport;
      bank_wdata_d = outport;
    end else if (host_wr_d) begin
      bank_we_d    = 1'b1;
      bank_waddr_d = h_addr_q;
      bank_wdata_d = h_wdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Port register bank
  // ---------------------------------------------------------------------------

  // Bank storage: ports 0 and 1 reset to INIT0/INIT1, the rest to zero.
  // At most one write per cycle.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: this bank has architected reset values, so it is built from flops
    // and reset in full. A storage array without reset values would be left
    // out of the reset branch, so that it can map to RAM.
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        bank_q[i] <= (i == 0) ? INIT0 : (i == 1) ? INIT1 : 16'd0;
      end
    end else if (bank_we_d) begin
      bank_q[bank_waddr_d] <= bank_wdata_d;
    end
  end

  // CPU read path. It has no bypass: a same-cycle write shows up only after the edge.
  assign inport = bank_q[dirport];

  // ---------------------------------------------------------------------------
  // Host handshake FSM
  // ---------------------------------------------------------------------------

  // Host handshake FSM. It drives registered gnt/done/hold, the captured request,
  // read data, the wait counter and the conflict counter.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, which is what gives the ACC read its
    // old-value semantics against a CPU write in the same cycle.
    if (reset) begin
      state_q        <= ST_IDLE;
      h_we_q         <= 1'b0;
      h_addr_q       <= 5'd0;
      h_wdata_q      <= 16'd0;
      h_gnt_q        <= 1'b0;
      h_done_q       <= 1'b0;
      ms_hold_q      <= 1'b0;
      h_rdata_q      <= 16'd0;
      wait_cnt_q     <= 4'd0;
      conflict_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (h_req) begin
            h_we_q    <= h_we;
            h_addr_q  <= h_addr;
            h_wdata_q <= h_wdata;
            h_gnt_q   <= 1'b1;
            state_q   <= ST_ACC;
          end
        end

        ST_ACC: begin
          if (!h_we_q) begin
            // Old value: any CPU write at this edge lands after the sample.
            h_rdata_q <= bank_q[h_addr_q];
            h_done_q  <= 1'b1;
            state_q   <= ST_DONE;
          end else if (!we) begin
            // The write port is free, so the bank takes the host data at this edge.
            h_done_q <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            // The CPU owns the single write port, whatever address it targets.
            wait_cnt_q <= 4'd1;
            ms_hold_q  <= (MAX_WAIT_CNT == 4'd1);
            state_q    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          conflict_cnt_q <= conflict_cnt_d;
          if (!we) begin
            // The port has come free, so the deferred host write lands at this edge.
            wait_cnt_q <= 4'd0;
            ms_hold_q  <= 1'b0;
            h_done_q   <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            ms_hold_q  <= (wait_cnt_d == MAX_WAIT_CNT);
          end
        end

        ST_DONE: begin
          h_gnt_q  <= 1'b0;
          h_done_q <= 1'b0;
          state_q  <= ST_IDLE;
        end

        default: begin
          h_gnt_q    <= 1'b0;
          h_done_q   <= 1'b0;
          ms_hold_q  <= 1'b0;
          wait_cnt_q <= 4'd0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign h_gnt        = h_gnt_q;
  assign h_done       = h_done_q;
  assign h_rdata      = h_rdata_q;
  assign ms_hold      = ms_hold_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_ms_port_ctrl.sv
// tb_ms_port_ctrl
// Directed testbench for ms_port_ctrl with default parameters
// (INIT0=2, INIT1=4, MAX_WAIT=4). Uncontended host transactions come from a
// vector table. Contention, hold, same-address, back-to-back and reset-abort
// cases are hand-written sequences. Inputs are driven and outputs sampled
// 1 ns after each rising edge.

module tb_ms_port_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dirport;
  logic [15:0] outport;
  logic        we;
  logic [15:0] inport;
  logic        ms_hold;
  logic        h_req;
  logic        h_we;
  logic [4:0]  h_addr;
  logic [15:0] h_wdata;
  logic        h_gnt;
  logic        h_done;
  logic [15:0] h_rdata;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  ms_port_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .dirport      (dirport),
    .outport      (outport),
    .we           (we),
    .inport       (inport),
    .ms_hold      (ms_hold),
    .h_req        (h_req),
    .h_we         (h_we),
    .h_addr       (h_addr),
    .h_wdata      (h_wdata),
    .h_gnt        (h_gnt),
    .h_done       (h_done),
    .h_rdata      (h_rdata),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  dir;
    logic [15:0] exp_inport;
  } rst_vec_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;  // h_rdata after the transaction (unchanged by writes)
    logic [15:0] exp_port;   // bank[addr] after the transaction
  } host_vec_t;

  rst_vec_t  rv [4];
  host_vec_t hv [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One uncontended host transaction with handshake timing and readback checks.
  task automatic host_txn(input host_vec_t v, input int idx);
    h_req   = 1'b1;
    h_we    = v.we;
    h_addr  = v.addr;
    h_wdata = v.wdata;
    dirport = ~v.addr;
    step();  // request sampled -> ACC
    check($sformatf("v%0d gnt in ACC", idx), h_gnt, 1'b1);
    check($sformatf("v%0d done in ACC", idx), h_done, 1'b0);
    // Scramble the host pins; the captured request must not follow them.
    h_req   = 1'b0;
    h_we    = ~v.we;
    h_addr  = ~v.addr;
    h_wdata = ~v.wdata;
    step();  // -> DONE
    check($sformatf("v%0d done pulse", idx), h_done, 1'b1);
    check($sformatf("v%0d gnt in DONE", idx), h_gnt, 1'b1);
    check($sformatf("v%0d rdata", idx), h_rdata, v.exp_rdata);
    dirport = v.addr;
    #1;
    check($sformatf("v%0d inport", idx), inport, v.exp_port);
    step();  // -> IDLE
    check($sformatf("v%0d gnt idle", idx), h_gnt, 1'b0);
    check($sformatf("v%0d done idle", idx), h_done, 1'b0);
    check($sformatf("v%0d conflict_cnt", idx), conflict_cnt, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rv[0] = '{5'd0,  16'd2};
    rv[1] = '{5'd1,  16'd4};
    rv[2] = '{5'd7,  16'd0};
    rv[3] = '{5'd31, 16'd0};

    hv[0] = '{1'b0, 5'd1,  16'h0000, 16'd4,    16'd4};
    hv[1] = '{1'b1, 5'd3,  16'hBEEF, 16'd4,    16'hBEEF};
    hv[2] = '{1'b0, 5'd3,  16'h0000, 16'hBEEF, 16'hBEEF};
    hv[3] = '{1'b1, 5'd31, 16'h0F0F, 16'hBEEF, 16'h0F0F};
    hv[4] = '{1'b0, 5'd31, 16'h0000, 16'h0F0F, 16'h0F0F};
    hv[5] = '{1'b0, 5'd0,  16'h0000, 16'd2,    16'd2};
    hv[6] = '{1'b1, 5'd7,  16'hA5A5, 16'd2,    16'hA5A5};

    reset   = 1'b1;
    dirport = 5'd0;
    outport = 16'd0;
    we      = 1'b0;
    h_req   = 1'b0;
    h_we    = 1'b0;
    h_addr  = 5'd0;
    h_wdata = 16'd0;
    step();
    step();
    reset = 1'b0;

    // ---- reset state ----
    for (int i = 0; i < 4; i++) begin
      dirport = rv[i].dir;
      #1;
      check($sformatf("reset inport[%0d]", rv[i].dir), inport, rv[i].exp_inport);
    end
    check("reset h_gnt", h_gnt, 1'b0);
    check("reset h_done", h_done, 1'b0);
    check("reset h_rdata", h_rdata, 16'd0);
    check("reset ms_hold", ms_hold, 1'b0);
    check("reset conflict_cnt", conflict_cnt, 16'd0);

    // ---- uncontended transactions ----
    for (int i = 0; i < 7; i++) begin
      host_txn(hv[i], i);
    end

    // ---- host read and CPU write to the same address in the same cycle ----
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd2;
    step();  // ACC
    h_req = 1'b0; dirport = 5'd2; outport = 16'h7777; we = 1'b1;
    #1;
    check("same-addr no bypass", inport, 16'd0);
    step();  // DONE; CPU value lands
    we = 1'b0;
    check("same-addr done", h_done, 1'b1);
    check("same-addr rdata old", h_rdata, 16'd0);
    check("same-addr cpu landed", inport, 16'h7777);
    step();
    check("same-addr idle gnt", h_gnt, 1'b0);
    check("same-addr conflict", conflict_cnt, 16'd0);

    // ---- h_req held high: back-to-back reads with one IDLE cycle between ----
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd1;
    step();
    check("b2b gnt 1", h_gnt, 1'b1);
    step();
    check("b2b done 1", h_done, 1'b1);
    step();
    check("b2b idle gap gnt", h_gnt, 1'b0);
    check("b2b idle gap done", h_done, 1'b0);
    step();
    check("b2b gnt 2", h_gnt, 1'b1);
    h_req = 1'b0;
    step();
    check("b2b done 2", h_done, 1'b1);
    check("b2b rdata", h_rdata, 16'd4);
    step();

    // ---- contended write: CPU writes for 2 cycles ----
    h_req = 1'b1; h_we = 1'b1; h_addr = 5'd5; h_wdata = 16'h1234;
    step();  // ACC
    h_req = 1'b0; we = 1'b1; dirport = 5'd9; outport = 16'hAAAA;
    step();  // WAIT 1
    check("cont wait1 gnt", h_gnt, 1'b1);
    check("cont wait1 done", h_done, 1'b0);
    check("cont wait1 hold", ms_hold, 1'b0);
    step();  // WAIT 2
    check("cont wait2 done", h_done, 1'b0);
    check("cont wait2 hold", ms_hold, 1'b0);
    we = 1'b0;
    step();  // DONE
    check("cont done", h_done, 1'b1);
    check("cont done hold", ms_hold, 1'b0);
    check("cont conflict_cnt", conflict_cnt, 16'd2);
    dirport = 5'd5;
    #1;
    check("cont host data", inport, 16'h1234);
    dirport = 5'd9;
    #1;
    check("cont cpu data", inport, 16'hAAAA);
    step();

    // ---- persistent contention raises ms_hold in the 4th WAIT cycle ----
    h_req = 1'b1; h_we = 1'b1; h_addr = 5'd6; h_wdata = 16'h5678;
    step();  // ACC
    h_req = 1'b0; we = 1'b1; dirport = 5'd10; outport = 16'h1111;
    for (int n = 1; n <= 4; n++) begin
      step();  // WAIT n
      check($sformatf("hold wait%0d", n), ms_hold, (n == 4) ? 1'b1 : 1'b0);
      check($sformatf("hold wait%0d done", n), h_done, 1'b0);
    end
    we = 1'b0;
    step();  // DONE
    check("hold released", ms_hold, 1'b0);
    check("hold done", h_done, 1'b1);
    check("hold conflict_cnt", conflict_cnt, 16'd6);
    dirport = 5'd6;
    #1;
    check("hold host data", inport, 16'h5678);
    step();

    // ---- reset while in WAIT aborts the transaction ----
    h_req = 1'b1; h_we = 1'b1; h_addr = 5'd0; h_wdata = 16'hFFFF;
    step();  // ACC
    h_req = 1'b0; we = 1'b1; dirport = 5'd20; outport = 16'h3333;
    step();  // WAIT 1
    step();  // WAIT 2
    check("abort pre gnt", h_gnt, 1'b1);
    check("abort pre conflict", conflict_cnt, 16'd7);
    #1;
    reset = 1'b1;
    #1;
    we = 1'b0;
    dirport = 5'd0;
    #1;
    check("abort gnt", h_gnt, 1'b0);
    check("abort hold", ms_hold, 1'b0);
    check("abort conflict_cnt", conflict_cnt, 16'd0);
    check("abort inport[0]", inport, 16'd2);
    step();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("abort no done %0d", n), h_done, 1'b0);
      check($sformatf("abort idle gnt %0d", n), h_gnt, 1'b0);
    end
    check("abort inport[0] kept", inport, 16'd2);
    dirport = 5'd20;
    #1;
    check("abort inport[20]", inport, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
